// File: rtl/awg_param_ctrl_pkg.sv
// Shared field encoding, amplitude bounds and reset defaults for the AWG
// front-panel controller and the waveform generators it feeds.
package awg_pkg;

    typedef enum logic [1:0] {
        FIELD_FREQ  = 2'd0,
        FIELD_AMP   = 2'd1,
        FIELD_PHASE = 2'd2
    } field_e;

    localparam logic [2:0]  AMP_MIN          = 3'd1;
    localparam logic [2:0]  AMP_MAX          = 3'd7;
    localparam logic [2:0]  AMP_RST          = 3'd1;
    localparam logic [11:0] FREQ_RST_DEFAULT = 12'd64;
    localparam logic [7:0]  PHASE_RST        = 8'd0;

    // FREQ -> AMP -> PHASE -> FREQ; the unused code 3 also returns to FREQ.
    function automatic field_e nextField(input field_e f);
        case (f)
            FIELD_FREQ:  return FIELD_AMP;
            FIELD_AMP:   return FIELD_PHASE;
            default:     return FIELD_FREQ;
        endcase
    endfunction

endpackage

// File: rtl/awg_param_ctrl_key_debounce.sv
// One push-button path: 2-flop synchroniser, stable-count filter and a
// one-cycle pulse on the debounced rising edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_levelDly;
    logic [CW-1:0] r_cnt;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0    <= 1'b0;
            r_sync1    <= 1'b0;
            r_level    <= 1'b0;
            r_levelDly <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync0    <= i_key;
            r_sync1    <= r_sync0;
            r_levelDly <= r_level;
            if (r_sync1 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_level & ~r_levelDly;

endmodule

// File: rtl/awg_param_ctrl.sv
// Front-panel parameter controller: debounced keys drive a field FSM that
// updates freq/amp/phase and toggles the generator enable.
// Optional key auto-repeat is built when AWG_AUTO_REPEAT_EN is defined.
module awg_param_ctrl
    import awg_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] FREQ_STEP       = 12'd16,
    parameter logic [11:0] FREQ_MIN        = 12'd16,
    parameter logic [11:0] FREQ_MAX        = 12'd4080,
    parameter logic [7:0]  PHASE_STEP      = 8'd16,
    parameter logic [11:0] FREQ_RST        = FREQ_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        wave_en,
    output logic [1:0]  cur_field
);

    logic w_modeLevel, w_upLevel, w_downLevel, w_enLevel;
    logic w_modePulse, w_upPulse, w_downPulse, w_enPulse;
    logic w_rptUp, w_rptDown;
    logic w_up, w_down;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyMode (
        .clk(clk), .rst(rst), .i_key(key_mode), .o_level(w_modeLevel), .o_pulse(w_modePulse));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyUp (
        .clk(clk), .rst(rst), .i_key(key_up), .o_level(w_upLevel), .o_pulse(w_upPulse));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyDown (
        .clk(clk), .rst(rst), .i_key(key_down), .o_level(w_downLevel), .o_pulse(w_downPulse));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyEn (
        .clk(clk), .rst(rst), .i_key(key_en), .o_level(w_enLevel), .o_pulse(w_enPulse));

`ifdef AWG_AUTO_REPEAT_EN
    localparam int RW = $clog2(32 * DEBOUNCE_CYCLES + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(32 * DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(8 * DEBOUNCE_CYCLES - 1);

    logic [RW-1:0] r_rptCnt;
    logic          r_rptFirst;
    logic          w_rptHold;
    logic          w_rptFire;

    assign w_rptHold = w_upLevel | w_downLevel;
    assign w_rptFire = w_rptHold && (r_rptCnt == (r_rptFirst ? RPT_FIRST : RPT_NEXT));

    // A fresh press or a mode step restarts the long initial delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptCnt   <= '0;
            r_rptFirst <= 1'b1;
        end else if (!w_rptHold || w_modePulse || w_upPulse || w_downPulse) begin
            r_rptCnt   <= '0;
            r_rptFirst <= 1'b1;
        end else if (w_rptFire) begin
            r_rptCnt   <= '0;
            r_rptFirst <= 1'b0;
        end else begin
            r_rptCnt <= r_rptCnt + 1'b1;
        end
    end

    assign w_rptUp   = w_rptFire & w_upLevel;
    assign w_rptDown = w_rptFire & w_downLevel;
`else
    assign w_rptUp   = 1'b0;
    assign w_rptDown = 1'b0;
`endif

    assign w_up   = w_upPulse | w_rptUp;
    assign w_down = w_downPulse | w_rptDown;

    field_e      r_field;
    logic [11:0] r_freq;
    logic [2:0]  r_amp;
    logic [7:0]  r_phase;
    logic        r_waveEn;

    // 13-bit arithmetic keeps the saturation compare free of wrap-around.
    logic [12:0] w_freqUp13, w_freqDn13;
    logic [11:0] w_freqInc, w_freqDec;
    logic [2:0]  w_ampInc, w_ampDec;

    assign w_freqUp13 = {1'b0, r_freq} + {1'b0, FREQ_STEP};
    assign w_freqDn13 = {1'b0, r_freq} - {1'b0, FREQ_STEP};
    assign w_freqInc  = (w_freqUp13 > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_freqUp13[11:0];
    assign w_freqDec  = (w_freqDn13[12] || (w_freqDn13 < {1'b0, FREQ_MIN})) ? FREQ_MIN : w_freqDn13[11:0];
    assign w_ampInc   = (r_amp >= AMP_MAX) ? AMP_MAX : r_amp + 3'd1;
    assign w_ampDec   = (r_amp <= AMP_MIN) ? AMP_MIN : r_amp - 3'd1;

    // A mode step wins over any adjust; opposing up/down cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_field  <= FIELD_FREQ;
            r_freq   <= FREQ_RST;
            r_amp    <= AMP_RST;
            r_phase  <= PHASE_RST;
            r_waveEn <= 1'b0;
        end else begin
            if (w_enPulse) begin
                r_waveEn <= ~r_waveEn;
            end
            if (w_modePulse) begin
                r_field <= nextField(r_field);
            end else if (w_up ^ w_down) begin
                case (r_field)
                    FIELD_FREQ:  r_freq  <= w_up ? w_freqInc : w_freqDec;
                    FIELD_AMP:   r_amp   <= w_up ? w_ampInc : w_ampDec;
                    FIELD_PHASE: r_phase <= w_up ? r_phase + PHASE_STEP : r_phase - PHASE_STEP;
                    default:     r_field <= FIELD_FREQ;
                endcase
            end
        end
    end

    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign wave_en     = r_waveEn;
    assign cur_field   = r_field;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// Self-checking bench for awg_param_ctrl with DEBOUNCE_CYCLES=4, comparing
// against a press-level behavioural model of the front panel.
module tb_awg_param_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_mode = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic        key_en = 1'b0;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        wave_en;
    logic [1:0]  cur_field;

    int nCompared = 0;
    int nMismatched = 0;

    int mFreq, mAmp, mPhase, mEn, mField;

    awg_param_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .key_mode(key_mode), .key_up(key_up), .key_down(key_down), .key_en(key_en),
        .state_freq(state_freq), .state_amp(state_amp), .state_phase(state_phase),
        .wave_en(wave_en), .cur_field(cur_field)
    );

    always #5 clk = ~clk;

    logic [25:0] dutVec;
    assign dutVec = {state_freq, state_amp, state_phase, wave_en, cur_field};

    function automatic logic [25:0] modelVec();
        return {12'(mFreq), 3'(mAmp), 8'(mPhase), 1'(mEn), 2'(mField)};
    endfunction

    function automatic void modelReset();
        mFreq = 64; mAmp = 1; mPhase = 0; mEn = 0; mField = 0;
    endfunction

    // One complete debounced press of the keys in {mode, up, down, en}.
    function automatic void modelPress(input logic [3:0] keys);
        if (keys[0]) mEn = 1 - mEn;
        if (keys[3]) begin
            mField = (mField + 1) % 3;
        end else if (keys[2] != keys[1]) begin
            if (mField == 0) mFreq = keys[2] ? ((mFreq + 16 > 4080) ? 4080 : mFreq + 16)
                                             : ((mFreq - 16 < 16) ? 16 : mFreq - 16);
            else if (mField == 1) mAmp = keys[2] ? ((mAmp >= 7) ? 7 : mAmp + 1)
                                                 : ((mAmp <= 1) ? 1 : mAmp - 1);
            else mPhase = keys[2] ? (mPhase + 16) % 256 : (mPhase + 256 - 16) % 256;
        end
    endfunction

    task automatic applyStimulus(input logic [3:0] keys, input int hold);
        @(negedge clk);
        {key_mode, key_up, key_down, key_en} = keys;
        repeat (hold) @(negedge clk);
        {key_mode, key_up, key_down, key_en} = 4'b0000;
        repeat (10) @(negedge clk);
        modelPress(keys);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            nCompared++;
            if (dutVec !== modelVec()) begin
                nMismatched++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", i, dutVec, modelVec());
            end
        end
    endtask

    task automatic test_glitch_latency();
        int changes;
        logic [11:0] lastFreq;
        @(negedge clk);
        key_up = 1'b1;
        repeat (3) @(negedge clk);
        key_up = 1'b0;
        repeat (12) @(negedge clk);
        nCompared++;
        if (dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL glitch: got %h expected %h", dutVec, modelVec());
        end
        @(negedge clk);
        key_up = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (state_freq !== 12'd64) begin
            nMismatched++;
            $display("[TB] FAIL latency_early: got %0d expected 64", state_freq);
        end
        @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (state_freq !== 12'd80) begin
            nMismatched++;
            $display("[TB] FAIL latency_edge7: got %0d expected 80", state_freq);
        end
        changes = 0;
        lastFreq = state_freq;
        for (int i = 0; i < 30; i++) begin
            if (i == 13) key_up = 1'b0;
            @(negedge clk);
            if (state_freq !== lastFreq) changes++;
            lastFreq = state_freq;
        end
        modelPress(4'b0100);
        nCompared++;
        if (changes !== 0 || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL single_update: extra changes %0d, got %h expected %h", changes, dutVec, modelVec());
        end
    endtask

    task automatic test_phase_wrap();
        applyStimulus(4'b1000, 8);
        applyStimulus(4'b1000, 8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 8);
            nCompared++;
            if (state_phase !== 8'(256 - 16 * (i + 1)) || dutVec !== modelVec()) begin
                nMismatched++;
                $display("[TB] FAIL phase_wrap %0d: got %h expected %h", i, dutVec, modelVec());
            end
        end
        applyStimulus(4'b1000, 8);
        nCompared++;
        if (cur_field !== 2'd0 || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL field_wrap: got %h expected %h", dutVec, modelVec());
        end
    endtask

    task automatic test_saturation();
        applyStimulus(4'b1000, 8);
        for (int i = 0; i < 10; i++) applyStimulus(4'b0100, 7);
        nCompared++;
        if (state_amp !== 3'd7 || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL amp_max: got %h expected %h", dutVec, modelVec());
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0010, 7);
            nCompared++;
            if (state_amp === 3'd0 || dutVec !== modelVec()) begin
                nMismatched++;
                $display("[TB] FAIL amp_down %0d: got %h expected %h", i, dutVec, modelVec());
            end
        end
        applyStimulus(4'b1000, 8);
        applyStimulus(4'b1000, 8);
        for (int i = 0; i < 300; i++) applyStimulus(4'b0100, 6);
        nCompared++;
        if (state_freq !== 12'd4080 || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL freq_max: got %h expected %h", dutVec, modelVec());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] fieldBefore;
        logic [11:0] freqBefore;
        applyStimulus(4'b0010, 8);
        fieldBefore = cur_field;
        freqBefore = state_freq;
        applyStimulus(4'b1100, 8);
        nCompared++;
        if (cur_field !== 2'((fieldBefore + 1) % 3) || state_freq !== freqBefore || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL mode_plus_up: got %h expected %h", dutVec, modelVec());
        end
        applyStimulus(4'b0110, 8);
        nCompared++;
        if (dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL up_plus_down: got %h expected %h", dutVec, modelVec());
        end
    endtask

    task automatic test_random();
        logic [3:0] keys;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: keys = 4'b1000;
                1, 2: keys = 4'b0100;
                3, 4: keys = 4'b0010;
                5: keys = 4'b0001;
                6: keys = 4'b0101;
                default: keys = 4'($urandom_range(1, 15));
            endcase
            applyStimulus(keys, $urandom_range(6, 12));
            nCompared++;
            if (dutVec !== modelVec()) begin
                nMismatched++;
                $display("[TB] FAIL random %0d keys %b: got %h expected %h", i, keys, dutVec, modelVec());
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int toggles;
        logic lastEn;
        @(negedge clk);
        key_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        nCompared++;
        if (wave_en !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL en_in_reset: got %b expected 0", wave_en);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        toggles = 0;
        lastEn = wave_en;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) key_en = 1'b0;
            @(negedge clk);
            if (wave_en !== lastEn) toggles++;
            lastEn = wave_en;
        end
        repeat (10) @(negedge clk);
        modelPress(4'b0001);
        nCompared++;
        if (toggles !== 1 || wave_en !== 1'b1 || dutVec !== modelVec()) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_press: toggles %0d, got %h expected %h", toggles, dutVec, modelVec());
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_glitch_latency();
        test_phase_wrap();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
